// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control unit: opcodes, sequencer
// states, IR field positions and the per-state control strobe bundle.
package cpu_ctrl_pkg;

   localparam int unsigned OPC_W      = 5;
   localparam int unsigned REG_FLD_W  = 4;

   // IR field positions, shared with the datapath select/encode block
   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned RA_MSB     = 26;
   localparam int unsigned RB_MSB     = 22;
   localparam int unsigned RC_MSB     = 18;

   typedef logic [OPC_W-1:0] opcode_t;

   localparam opcode_t OP_ADD  = 5'b00011;
   localparam opcode_t OP_SUB  = 5'b00100;
   localparam opcode_t OP_AND  = 5'b01001;
   localparam opcode_t OP_OR   = 5'b01010;
   localparam opcode_t OP_NOP  = 5'b11010;
   localparam opcode_t OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      ST_RESET = 4'd0,
      ST_T0    = 4'd1,
      ST_T1    = 4'd2,
      ST_T2    = 4'd3,
      ST_T3    = 4'd4,
      ST_T4    = 4'd5,
      ST_T5    = 4'd6,
      ST_PAUSE = 4'd7,
      ST_HALT  = 4'd8
   } state_e;

   typedef struct packed {
      logic pcout;
      logic zlowout;
      logic mdrout;
      logic marin;
      logic pcin;
      logic mdrin;
      logic irin;
      logic yin;
      logic zin;
      logic incpc;
      logic read;
      logic gra;
      logic grb;
      logic grc;
      logic rin;
      logic rout;
      logic run;
   } ctrl_t;

   // Output ROM: strobes asserted in each state
   function automatic ctrl_t state_ctrl(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         ST_T0: begin
            c.pcout = 1'b1; c.marin = 1'b1; c.incpc = 1'b1; c.zin = 1'b1; c.run = 1'b1;
         end
         ST_T1: begin
            c.zlowout = 1'b1; c.pcin = 1'b1; c.read = 1'b1; c.mdrin = 1'b1; c.run = 1'b1;
         end
         ST_T2: begin
            c.mdrout = 1'b1; c.irin = 1'b1; c.run = 1'b1;
         end
         ST_T3: begin
            c.grb = 1'b1; c.rout = 1'b1; c.yin = 1'b1; c.run = 1'b1;
         end
         ST_T4: begin
            c.grc = 1'b1; c.rout = 1'b1; c.zin = 1'b1; c.run = 1'b1;
         end
         ST_T5: begin
            c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; c.run = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier for the control sequencer.
module ctrl_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W = OPC_W
) (
   input  logic [OPCODE_W-1:0] opcode,
   output logic                is_alu,
   output logic                is_nop,
   output logic                is_halt,
   output logic                is_illegal
);

   always_comb begin
      is_alu     = 1'b0;
      is_nop     = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      case (opcode)
         OPCODE_W'(OP_ADD),
         OPCODE_W'(OP_SUB),
         OPCODE_W'(OP_AND),
         OPCODE_W'(OP_OR):   is_alu     = 1'b1;
         OPCODE_W'(OP_NOP):  is_nop     = 1'b1;
         OPCODE_W'(OP_HALT): is_halt    = 1'b1;
         default:            is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer driving the datapath control strobes.
// Define CTRL_ILLEGAL_TRAP_EN to halt with a sticky Illegal flag on unknown opcodes.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned IR_W     = 32,
   parameter int unsigned OPCODE_W = OPC_W,
   parameter int unsigned ALUOP_W  = 5
) (
   input  logic               Clock,
   input  logic               Reset_n,
   input  logic [IR_W-1:0]    IR,
   input  logic               Mem_ready,
   input  logic               Stop,
   output logic               PCout,
   output logic               Zlowout,
   output logic               MDRout,
   output logic               MARin,
   output logic               PCin,
   output logic               MDRin,
   output logic               IRin,
   output logic               Yin,
   output logic               Zin,
   output logic               IncPC,
   output logic               Read,
   output logic               Gra,
   output logic               Grb,
   output logic               Grc,
   output logic               Rin,
   output logic               Rout,
   output logic [ALUOP_W-1:0] Alu_op,
   output logic               Run,
   output logic               Illegal
);

   logic [OPCODE_W-1:0] opcode_c;
   logic                is_alu, is_nop, is_halt, is_illegal;
   logic                trap_c;
   logic                unused_ir;

   state_e              state_q, state_d;
   state_e              boundary_c;
   logic [OPCODE_W-1:0] op_q, op_d;
   ctrl_t               ctrl_q, ctrl_d;
   logic [ALUOP_W-1:0]  alu_op_q, alu_op_d;
   logic                illegal_q, illegal_d;

   assign opcode_c  = IR[IR_W-1 -: OPCODE_W];
   assign unused_ir = ^IR[IR_W-OPCODE_W-1:0];

   ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
      .opcode     (opcode_c),
      .is_alu     (is_alu),
      .is_nop     (is_nop),
      .is_halt    (is_halt),
      .is_illegal (is_illegal)
   );

`ifdef CTRL_ILLEGAL_TRAP_EN
   assign trap_c = is_illegal;
`else
   logic unused_illegal;
   assign unused_illegal = is_illegal;
   assign trap_c         = 1'b0;
`endif

   // Outputs are registered from the next state so they line up with the state
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= ST_RESET;
         op_q      <= '0;
         ctrl_q    <= '0;
         alu_op_q  <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         ctrl_q    <= ctrl_d;
         alu_op_q  <= alu_op_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      boundary_c = Stop ? ST_PAUSE : ST_T0;
      case (state_q)
         ST_RESET: state_d = ST_T0;
         ST_T0:    state_d = ST_T1;
         ST_T1:    if (Mem_ready) state_d = ST_T2;
         ST_T2: begin
            // IR is only trusted on the edge leaving T2
            if (is_alu) begin
               state_d = ST_T3;
               op_d    = opcode_c;
            end else if (is_halt) begin
               state_d = ST_HALT;
            end else if (is_nop || !trap_c) begin
               state_d = boundary_c;
            end else begin
               state_d = ST_HALT;
            end
         end
         ST_T3:    state_d = ST_T4;
         ST_T4:    state_d = ST_T5;
         ST_T5:    state_d = boundary_c;
         ST_PAUSE: if (!Stop) state_d = ST_T0;
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_RESET;
      endcase

      ctrl_d    = state_ctrl(state_d);
      alu_op_d  = (state_d == ST_T4) ? ALUOP_W'(op_q) : '0;
      illegal_d = illegal_q | ((state_q == ST_T2) & trap_c);
   end

   assign PCout   = ctrl_q.pcout;
   assign Zlowout = ctrl_q.zlowout;
   assign MDRout  = ctrl_q.mdrout;
   assign MARin   = ctrl_q.marin;
   assign PCin    = ctrl_q.pcin;
   assign MDRin   = ctrl_q.mdrin;
   assign IRin    = ctrl_q.irin;
   assign Yin     = ctrl_q.yin;
   assign Zin     = ctrl_q.zin;
   assign IncPC   = ctrl_q.incpc;
   assign Read    = ctrl_q.read;
   assign Gra     = ctrl_q.gra;
   assign Grb     = ctrl_q.grb;
   assign Grc     = ctrl_q.grc;
   assign Rin     = ctrl_q.rin;
   assign Rout    = ctrl_q.rout;
   assign Run     = ctrl_q.run;
   assign Alu_op  = alu_op_q;
   assign Illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-cycle reference model plus
// directed scenarios with literal expectations. Honours CTRL_ILLEGAL_TRAP_EN.
module tb_control_sequencer;

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b1;
   logic [31:0] IR;
   logic        Mem_ready;
   logic        Stop;
   logic        PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, IncPC;
   logic        Read, Gra, Grb, Grc, Rin, Rout, Run, Illegal;
   logic [4:0]  Alu_op;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   control_sequencer dut (
      .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .PCin(PCin),
      .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .IncPC(IncPC), .Read(Read),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .Alu_op(Alu_op),
      .Run(Run), .Illegal(Illegal)
   );

   always #5 Clock = ~Clock;

   // Strobe vector bit positions
   localparam int B_PCOUT = 16, B_ZLOW = 15, B_MDROUT = 14, B_MARIN = 13, B_PCIN = 12;
   localparam int B_MDRIN = 11, B_IRIN = 10, B_YIN = 9, B_ZIN = 8, B_INCPC = 7, B_READ = 6;
   localparam int B_GRA = 5, B_GRB = 4, B_GRC = 3, B_RIN = 2, B_ROUT = 1, B_RUN = 0;

   function automatic logic [16:0] dut_vec();
      return {PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, IncPC,
              Read, Gra, Grb, Grc, Rin, Rout, Run};
   endfunction

   function automatic logic [16:0] bits(input int a, input int b, input int c, input int d);
      logic [16:0] v;
      v = 17'(1) << B_RUN;
      v[a] = 1'b1; v[b] = 1'b1; v[c] = 1'b1;
      if (d >= 0) v[d] = 1'b1;
      return v;
   endfunction

   // Model: step -1 = reset, 0..5 = instruction cycle index, 6 = paused, 7 = halted
   int         m_step = -1;
   logic [4:0] m_op   = '0;
   bit         m_ill  = 1'b0;

   function automatic logic [16:0] exp_vec(input int step);
      case (step)
         0: return bits(B_PCOUT, B_MARIN, B_INCPC, B_ZIN);
         1: return bits(B_ZLOW, B_PCIN, B_READ, B_MDRIN);
         2: return bits(B_MDROUT, B_IRIN, B_IRIN, -1);
         3: return bits(B_GRB, B_ROUT, B_YIN, -1);
         4: return bits(B_GRC, B_ROUT, B_ZIN, -1);
         5: return bits(B_ZLOW, B_GRA, B_RIN, -1);
         default: return 17'd0;
      endcase
   endfunction

   function automatic bit trap_build();
`ifdef CTRL_ILLEGAL_TRAP_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge Clock or negedge Reset_n) begin
      logic [4:0] opc;
      opc = IR[31:27];
      if (!Reset_n) begin
         m_step <= -1;
         m_ill  <= 1'b0;
      end else begin
         case (m_step)
            -1:      m_step <= 0;
            0:       m_step <= 1;
            1:       if (Mem_ready) m_step <= 2;
            2: begin
               if (opc inside {5'd3, 5'd4, 5'd9, 5'd10}) begin
                  m_step <= 3;
                  m_op   <= opc;
               end else if (opc == 5'd27) begin
                  m_step <= 7;
               end else if (opc == 5'd26 || !trap_build()) begin
                  m_step <= Stop ? 6 : 0;
               end else begin
                  m_step <= 7;
                  m_ill  <= 1'b1;
               end
            end
            3:       m_step <= 4;
            4:       m_step <= 5;
            5:       m_step <= Stop ? 6 : 0;
            6:       if (!Stop) m_step <= 0;
            default: m_step <= 7;
         endcase
      end
   end

   // Per-cycle comparison against the model
   always @(negedge Clock) begin
      if (chk_en) begin
         logic [4:0] exp_alu;
         exp_alu = (m_step == 4) ? m_op : 5'd0;
         checks = checks + 3;
         if (dut_vec() !== exp_vec(m_step)) begin
            failures++;
            $display("FAIL strobes t=%0t step=%0d got=%b exp=%b", $time, m_step, dut_vec(), exp_vec(m_step));
         end
         if (Alu_op !== exp_alu) begin
            failures++;
            $display("FAIL alu_op t=%0t step=%0d got=%b exp=%b", $time, m_step, Alu_op, exp_alu);
         end
         if (Illegal !== m_ill) begin
            failures++;
            $display("FAIL illegal t=%0t got=%b exp=%b", $time, Illegal, m_ill);
         end
      end
   end

   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=0x%0h exp=0x%0h", name, $time, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge Clock);
   endtask

   initial begin
      IR = 32'h0; Mem_ready = 1'b1; Stop = 1'b0;
      #1 Reset_n = 1'b0;
      chk_en = 1'b1;
      tick(2);
      lit("reset_strobes", 32'(dut_vec()), 32'h0);
      lit("reset_alu", 32'(Alu_op), 32'h0);
      lit("reset_illegal", 32'(Illegal), 32'h0);
      Reset_n = 1'b1;
      tick(1);
      lit("first_t0_pcout", 32'(PCout), 32'h1);
      lit("first_t0_vec", 32'(dut_vec()), 32'h12181);

      // and r5,r2,r4
      IR = 32'h4A920000;
      tick(1); lit("and_t1_read", 32'(Read), 32'h1);
      tick(1); lit("and_t2_irin", 32'(IRin & MDRout), 32'h1);
      tick(1); lit("and_t3_yin", 32'(Yin & Grb & Rout), 32'h1);
      tick(1); lit("and_t4_alu", 32'(Alu_op), 32'h09);
      tick(1); lit("and_t5_gra_rin", 32'(Gra & Rin & Zlowout), 32'h1);
               lit("and_t5_alu0", 32'(Alu_op), 32'h0);
      tick(1); lit("and_back_t0", 32'(PCout & Run), 32'h1);

      // add with three memory wait cycles
      IR = 32'h19920000; Mem_ready = 1'b0;
      tick(1); lit("wait_t1_c1", 32'(Read & MDRin), 32'h1);
      tick(3); lit("wait_t1_c4", 32'(Read & MDRin & PCin), 32'h1);
      Mem_ready = 1'b1;
      tick(1); lit("wait_t2", 32'(IRin), 32'h1);
      tick(2); lit("add_t4_alu", 32'(Alu_op), 32'h03);
      tick(2); lit("add_back_t0_9cyc", 32'(PCout), 32'h1);

      // nop: three cycles
      IR = 32'hD0000000;
      tick(2); lit("nop_t2", 32'(IRin), 32'h1);
      tick(1); lit("nop_back_t0", 32'(PCout & MARin), 32'h1);

      // sub with Stop raised during T4
      IR = 32'h20000000;
      tick(4); lit("stop_t4_alu", 32'(Alu_op), 32'h04);
      Stop = 1'b1;
      tick(1); lit("stop_t5_completes", 32'(Rin & Gra), 32'h1);
      tick(1); lit("pause_run", 32'(Run), 32'h0);
               lit("pause_no_t0", 32'(PCout), 32'h0);
      tick(1); lit("pause_held", 32'(dut_vec()), 32'h0);
      Stop = 1'b0;
      tick(1); lit("resume_t0", 32'(PCout & Run), 32'h1);

      // reset asserted in T3 of an OR
      IR = 32'h50000000;
      tick(3); lit("or_t3", 32'(Yin), 32'h1);
      Reset_n = 1'b0;
      #1;
      lit("midreset_strobes", 32'(dut_vec()), 32'h0);
      lit("midreset_alu", 32'(Alu_op), 32'h0);
      tick(1);
      Reset_n = 1'b1;
      tick(1); lit("rerelease_t0", 32'(PCout), 32'h1);

      // unknown opcode 11111
      IR = 32'hF8000000;
      tick(3);
`ifdef CTRL_ILLEGAL_TRAP_EN
      lit("illegal_flag", 32'(Illegal), 32'h1);
      lit("illegal_halt_run", 32'(Run), 32'h0);
      tick(5); lit("illegal_sticky", 32'(Illegal), 32'h1);
      Reset_n = 1'b0;
      #1; lit("illegal_cleared", 32'(Illegal), 32'h0);
      tick(1);
      Reset_n = 1'b1;
      tick(1);
`else
      lit("illegal_as_nop_flag", 32'(Illegal), 32'h0);
`endif
      lit("illegal_then_t0", 32'(PCout), 32'h1);

      // halt: only reset leaves
      IR = 32'hD8000000;
      tick(3); lit("halt_run", 32'(Run), 32'h0);
      tick(20); lit("halt_stays", 32'(dut_vec()), 32'h0);
      Reset_n = 1'b0;
      #1; lit("halt_reset", 32'(dut_vec()), 32'h0);
      tick(1);
      Reset_n = 1'b1; IR = 32'hD0000000;
      tick(1); lit("halt_exit_t0", 32'(PCout & Run), 32'h1);
      tick(4);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
